datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the single-port data memory (combinational read, synchronous word write, WORDS entries, word index = address[31:2]). Port 0 is the core load/store unit and port 1 is the debug/DMA loader. Ports are served round-robin, one transaction at a time. The block turns byte and halfword stores into a same-cycle read-merge-write of the addressed word, and flags misaligned or out-of-range accesses with an error response instead of touching memory.

Parameters:
WORDS, 64, number of 32-bit memory words; valid byte addresses are 0 .. 4*WORDS-1
ADDR_W, 32, request address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
p0_valid  in  1  port 0 request valid
p0_ready  out  1  port 0 request accepted this cycle
p0_we  in  1  1 = store, 0 = load
p0_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
p0_addr  in  ADDR_W  byte address
p0_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
p0_rsp_valid  out  1  one-cycle response pulse
p0_rsp_err  out  1  error flag, qualified by p0_rsp_valid
p0_rsp_rdata  out  32  full aligned word read; 0 on error or store
p1_*  —  same nine signals for port 1
mem_we  out  1  memory write enable
mem_addr  out  32  memory byte address
mem_wdata  out  32  merged word to write
mem_rdata  in  32  combinational memory read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0; rr_last = 1, so port 0 wins the first contention.
- IDLE:
  - If any pN_valid is high, select a winner. With one valid port, that port wins. With both valid, the port != rr_last wins.
  - Assert pN_ready combinationally for the winner only. Latch we/size/addr/wdata and the owner. Set rr_last = owner. Go to ACCESS.
  - The loser's ready stays 0; it must hold valid and its fields stable.
- ACCESS (exactly one cycle):
  - Drive mem_addr = latched addr.
  - err = (size == 11), or (size == half and addr[0]), or (size == word and addr[1:0] != 0), or (addr[ADDR_W-1:2] >= WORDS).
  - Load: capture mem_rdata, or 0 if err, into the response register.
  - Store without err:
    - mem_we = 1.
    - Word: mem_wdata = wdata.
    - Byte: replace lane addr[1:0] of mem_rdata with wdata[7:0].
    - Half: replace lane addr[1] of mem_rdata with wdata[15:0].
    - The write commits on the clock edge that ends ACCESS.
  - Store with err: mem_we = 0.
  - Go to RESP.
- RESP: assert pN_rsp_valid = 1 for the owner, with rsp_err and rsp_rdata (0 for stores), for exactly one cycle. There is no response back-pressure. Go to IDLE.
- Latency and throughput:
  - Accept at cycle T, memory access at T+1, response at T+2.
  - Next accept no earlier than T+3: peak one transaction per 3 cycles.
- mem_we is asserted only in ACCESS. mem_addr and mem_wdata are 0 outside ACCESS.
- rsp_rdata holds its value between responses; it is only qualified by rsp_valid.
- Reset asserted in any state:
  - Immediately forces IDLE with all outputs 0, including mem_we, so no partial write occurs.
  - An in-flight transaction is dropped with no response.
  - rr_last returns to 1.
- A valid that drops before ready is legal: nothing is granted to that port.

Decomposition:
- Package datamem_pkg:
  - size encoding (SZ_BYTE 2'b00, SZ_HALF 2'b01, SZ_WORD 2'b10)
  - FSM state enum (IDLE, ACCESS, RESP)
  - request struct (we, size, addr, wdata)
- Sub-module rr_arb2: 2-input round-robin grant with rr_last register, update enable and asynchronous reset.
- Store-merge and error checks stay inline.

Test Plan:
- Word store then load, port 0:
  - Store 0xDEADBEEF to 0x60; mem_we is 1 only at T+1, with mem_addr 0x60.
  - Then load 0x60: rsp_rdata = 0xDEADBEEF, err = 0, at T+2.
- Byte and half merge:
  - Word 0x11223344 at 0x10; store byte 0xAA to 0x12, then load 0x10 -> 0x11AA3344.
  - Store half 0xBEEF to 0x10, then load 0x10 -> 0x11AABEEF.
- Contention: p0 and p1 both valid from reset.
  - Grants are p0, p1, p0, p1 on successive IDLE cycles.
  - Accepts are spaced 3 cycles apart; each response goes only to its owner.
- Errors:
  - Word store to 0x62 -> err = 1, no mem_we, memory unchanged.
  - Load from 0x100 (WORDS = 64) -> err = 1, rdata = 0.
  - Size 11 -> err = 1.
- Reset during ACCESS of a store to 0x20:
  - mem_we drops immediately; memory at 0x20 keeps its old value; no rsp_valid.
  - After release, port 0 wins first contention.
- Single requester p1 with p0 idle: p1 is granted immediately even though rr_last = 1 at reset.

Source files
------------

// File: rtl/datamem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package datamem_pkg;

  // Access size encoding carried on pN_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Sequencer states: accept, one memory cycle, one response cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Latched request; the address is held at full memory-bus width.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Alignment / encoding error for a given size and low address bits.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lsb);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lsb[0];
      SZ_WORD: err = |lsb;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Bit mask of the lanes a store of this size overwrites.
  function automatic logic [31:0] store_mask(input logic [1:0] size, input logic [1:0] lsb);
    logic [31:0] mask;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << {lsb, 3'b000};
      SZ_HALF: mask = 32'h0000_FFFF << {lsb[1], 4'b0000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/datamem_arbiter_rr_arb2.sv
// Two-input round-robin grant. The port that did not win last time wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);

  logic last_q;
  logic last_d;
  logic winner_s;

  // Pick a winner from the current requests and the last owner.
  always_comb begin
    winner_s = 1'b0;
    grant_o  = 2'b00;
    if (req_i == 2'b11) begin
      winner_s = ~last_q;
    end else begin
      winner_s = req_i[1];
    end
    if (req_i != 2'b00) begin
      grant_o = winner_s ? 2'b10 : 2'b01;
    end else begin
      grant_o = 2'b00;
    end
    if (update_i) begin
      last_d = winner_s;
    end else begin
      last_d = last_q;
    end
  end

  // Remember the last owner; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign winner_o = winner_s;

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data
// memory. Sub-word stores are merged into the combinational read word.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_rsp_valid,
  output logic              p0_rsp_err,
  output logic [31:0]       p0_rsp_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_rsp_valid,
  output logic              p1_rsp_err,
  output logic [31:0]       p1_rsp_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic             owner_q, owner_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [1:0][31:0] rsp_rdata_q, rsp_rdata_d;

  logic       accept_s;
  logic [1:0] grant_s;
  logic [1:0] ready_s;
  logic       winner_s;
  logic       err_s;
  logic [31:0] mask_s;
  logic [31:0] merged_s;
  logic        mem_we_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({p1_valid, p0_valid}),
    .update_i (accept_s),
    .grant_o  (grant_s),
    .winner_o (winner_s)
  );

  // Error check and read-merge of the latched request against memory data.
  always_comb begin
    err_s    = size_err(req_q.size, req_q.addr[1:0]) |
               (req_q.addr[31:2] >= 30'(WORDS));
    mask_s   = store_mask(req_q.size, req_q.addr[1:0]);
    merged_s = (mem_rdata & ~mask_s) |
               ((req_q.wdata << {req_q.addr[1:0], 3'b000}) & mask_s);
  end

  // Sequencer next state, grant, memory strobes and response capture.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    accept_s    = 1'b0;
    ready_s     = 2'b00;
    mem_we_s    = 1'b0;
    mem_addr_s  = 32'h0000_0000;
    mem_wdata_s = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so nothing is granted while it is held.
        if (!reset && (p0_valid || p1_valid)) begin
          accept_s = 1'b1;
          ready_s  = grant_s;
          owner_d  = winner_s;
          if (winner_s) begin
            req_d.we    = p1_we;
            req_d.size  = p1_size;
            req_d.addr  = 32'(p1_addr);
            req_d.wdata = p1_wdata;
          end else begin
            req_d.we    = p0_we;
            req_d.size  = p0_size;
            req_d.addr  = 32'(p0_addr);
            req_d.wdata = p0_wdata;
          end
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_addr_s           = req_q.addr;
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d[owner_q]   = err_s;
        if (req_q.we && !err_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = merged_s;
        end else begin
          mem_we_s    = 1'b0;
        end
        if (!req_q.we && !err_s) begin
          rsp_rdata_d[owner_q] = mem_rdata;
        end else begin
          rsp_rdata_d[owner_q] = 32'h0000_0000;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign p0_ready     = ready_s[0];
  assign p1_ready     = ready_s[1];
  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_err   = rsp_err_q[0];
  assign p1_rsp_err   = rsp_err_q[1];
  assign p0_rsp_rdata = rsp_rdata_q[0];
  assign p1_rsp_rdata = rsp_rdata_q[1];
  assign mem_we       = mem_we_s;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: directed plan items plus random two-port traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_datamem_arbiter;

  localparam int WORDS = 64;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tb_req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Memory attached to the DUT.
  logic [31:0] ram [WORDS] = '{default: 32'h0};
  assign mem_rdata = (mem_addr[31:2] < 30'(WORDS)) ? ram[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && (mem_addr[31:2] < 30'(WORDS))) ram[mem_addr[7:2]] <= mem_wdata;
  end

  datamem_arbiter #(.WORDS(WORDS), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_size(p0_size),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_err(p0_rsp_err), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_size(p1_size),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_err(p1_rsp_err), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requesters.
  tb_req_t q0[$];
  tb_req_t q1[$];
  tb_req_t cur[2];
  bit      pend[2];
  bit      rand_mode = 1'b0;
  int      reset_hold = 3;
  bit      kill_armed = 1'b0;

  // Reference model.
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          in_flight = 1'b0;
  int          own = 0;
  tb_req_t     ex;
  bit          ex_err = 1'b0;
  logic [31:0] ex_rdata = 32'h0;
  bit          rr_last = 1'b1;
  logic [31:0] exp_rdata[2] = '{32'h0, 32'h0};
  logic [31:0] model_mem [WORDS] = '{default: 32'h0};

  // Observation logs taken from the DUT pins.
  int          grant_log[$];
  int          acc_log[$];
  logic [31:0] rsp0_data[$];
  logic        rsp0_err[$];
  logic [31:0] rsp1_data[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic tb_req_t mk(input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    tb_req_t r;
    r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic tb_req_t rand_req();
    tb_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    r.addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4*WORDS-1));
    if ($urandom_range(0, 3) != 0) begin
      if (r.size == 2'b10) r.addr[1:0] = 2'b00;
      else if (r.size == 2'b01) r.addr[0] = 1'b0;
    end
    r.wdata = $urandom;
    return r;
  endfunction

  // Predict this cycle's outputs from the rules, advance the model, compare.
  task automatic model_check();
    logic [1:0]  e_rdy, e_rv;
    logic        e_we, is_acc;
    logic [31:0] e_addr, e_wdata, old_w, new_w;
    int          lane, idx, win;
    e_rdy = 2'b00; e_rv = 2'b00; e_we = 1'b0; is_acc = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; idx = 0; win = 0;
    if (reset) begin
      in_flight = 1'b0; rr_last = 1'b1;
      exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    end else if (in_flight && cyc == acc_cyc + 1) begin
      is_acc = 1'b1;
      e_addr = ex.addr;
      ex_err = (ex.size == 2'b11) || (ex.size == 2'b01 && ex.addr[0]) ||
               (ex.size == 2'b10 && ex.addr[1:0] != 2'b00) || ((ex.addr >> 2) >= 32'(WORDS));
      old_w = 32'h0;
      if (!ex_err) begin
        idx   = int'(ex.addr >> 2);
        old_w = model_mem[idx];
      end
      ex_rdata = (!ex.we && !ex_err) ? old_w : 32'h0;
      if (ex.we && !ex_err) begin
        lane  = int'(ex.addr[1:0]);
        new_w = old_w;
        case (ex.size)
          2'b00:   new_w[8*lane +: 8] = ex.wdata[7:0];
          2'b01:   new_w[16*(lane/2) +: 16] = ex.wdata[15:0];
          default: new_w = ex.wdata;
        endcase
        e_we = 1'b1; e_wdata = new_w;
        model_mem[idx] = new_w;
      end
    end else if (in_flight && cyc == acc_cyc + 2) begin
      e_rv[own] = 1'b1;
      exp_rdata[own] = ex_rdata;
      in_flight = 1'b0;
    end else if (!in_flight && (p0_valid || p1_valid)) begin
      win = (p0_valid && p1_valid) ? int'(!rr_last) : int'(p1_valid);
      e_rdy[win] = 1'b1;
      ex = cur[win]; own = win; rr_last = 1'(win);
      acc_cyc = cyc; in_flight = 1'b1; pend[win] = 1'b0;
    end

    check_value("p0_ready", p0_ready, e_rdy[0]);
    check_value("p1_ready", p1_ready, e_rdy[1]);
    check_value("mem_we", mem_we, e_we);
    check_value("mem_addr", mem_addr, e_addr);
    if (e_we || !is_acc) check_value("mem_wdata", mem_wdata, e_wdata);
    check_value("p0_rsp_valid", p0_rsp_valid, e_rv[0]);
    check_value("p1_rsp_valid", p1_rsp_valid, e_rv[1]);
    if (e_rv[0]) check_value("p0_rsp_err", p0_rsp_err, ex_err);
    if (e_rv[1]) check_value("p1_rsp_err", p1_rsp_err, ex_err);
    check_value("p0_rsp_rdata", p0_rsp_rdata, exp_rdata[0]);
    check_value("p1_rsp_rdata", p1_rsp_rdata, exp_rdata[1]);

    if (p0_ready) begin grant_log.push_back(0); acc_log.push_back(cyc); end
    if (p1_ready) begin grant_log.push_back(1); acc_log.push_back(cyc); end
    if (p0_rsp_valid) begin rsp0_data.push_back(p0_rsp_rdata); rsp0_err.push_back(p0_rsp_err); end
    if (p1_rsp_valid) rsp1_data.push_back(p1_rsp_rdata);
  endtask

  // One clock: drive at the falling edge, check 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (kill_armed && in_flight && (cyc == acc_cyc + 1) && ex.we && (ex.addr == 32'h20)) begin
      reset_hold = 2;
      kill_armed = 1'b0;
    end
    reset = (reset_hold > 0);
    if (reset_hold > 0) reset_hold--;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); pend[0] = 1'b1; end
        else if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); pend[1] = 1'b1; end
        else if (rand_mode && $urandom_range(0, 3) == 0) begin cur[p] = rand_req(); pend[p] = 1'b1; end
      end else if (rand_mode && $urandom_range(0, 19) == 0) begin
        pend[p] = 1'b0;
      end
    end
    p0_valid = pend[0]; p0_we = cur[0].we; p0_size = cur[0].size;
    p0_addr  = cur[0].addr; p0_wdata = cur[0].wdata;
    p1_valid = pend[1]; p1_we = cur[1].we; p1_size = cur[1].size;
    p1_addr  = cur[1].addr; p1_wdata = cur[1].wdata;
    #1;
    model_check();
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      tick();
      n++;
      busy = (q0.size() > 0) || (q1.size() > 0) || pend[0] || pend[1] ||
             in_flight || reset || (reset_hold > 0);
    end
    if (busy) check_value("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset_hold = 2;
    tick();
    tick();
  endtask

  logic [31:0] gold_d[11] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11AA3344, 32'h0,
                              32'h11AABEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
  logic        gold_e[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int g, r0, r1;
    reset = 1'b1;
    p0_valid = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_addr = 32'h0; p1_wdata = 32'h0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    cur[0] = mk(1'b0, 2'b00, 32'h0, 32'h0);
    cur[1] = cur[0];
    repeat (4) tick();

    // Directed port-0 sequence: word, byte and half stores plus error cases.
    q0.push_back(mk(1'b1, 2'b10, 32'h60, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 2'b10, 32'h60, 32'h0));
    q0.push_back(mk(1'b1, 2'b10, 32'h10, 32'h11223344));
    q0.push_back(mk(1'b1, 2'b00, 32'h12, 32'h000000AA));
    q0.push_back(mk(1'b0, 2'b10, 32'h10, 32'h0));
    q0.push_back(mk(1'b1, 2'b01, 32'h10, 32'h0000BEEF));
    q0.push_back(mk(1'b0, 2'b10, 32'h10, 32'h0));
    q0.push_back(mk(1'b1, 2'b10, 32'h62, 32'h12345678));
    q0.push_back(mk(1'b0, 2'b10, 32'h60, 32'h0));
    q0.push_back(mk(1'b0, 2'b10, 32'h100, 32'h0));
    q0.push_back(mk(1'b0, 2'b11, 32'h10, 32'h0));
    run_until_idle(200);
    check_value("dir_rsp_count", 32'(rsp0_data.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < rsp0_data.size()) begin
        check_value($sformatf("dir%0d_rdata", i), rsp0_data[i], gold_d[i]);
        check_value($sformatf("dir%0d_err", i), rsp0_err[i], gold_e[i]);
      end
    end

    // Contention from reset: both ports hold valid through reset release.
    g = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 2'b10, 32'(8*i), 32'h0));
      q1.push_back(mk(1'b0, 2'b10, 32'(8*i + 4), 32'h0));
    end
    do_reset();
    run_until_idle(200);
    for (int i = 0; i < 4; i++) begin
      if (g + i < grant_log.size()) begin
        check_value($sformatf("rr_grant%0d", i), 32'(grant_log[g + i]), 32'(i % 2));
        if (i > 0) check_value($sformatf("rr_gap%0d", i),
                               32'(acc_log[g + i] - acc_log[g + i - 1]), 32'd3);
      end
    end

    // Reset during the memory cycle of a store to 0x20.
    q0.push_back(mk(1'b1, 2'b10, 32'h20, 32'hCAFEF00D));
    run_until_idle(100);
    kill_armed = 1'b1;
    q0.push_back(mk(1'b1, 2'b10, 32'h20, 32'h0BADC0DE));
    run_until_idle(100);
    check_value("kill_fired", 32'(kill_armed), 32'd0);
    g  = grant_log.size();
    r0 = rsp0_data.size();
    r1 = rsp1_data.size();
    q0.push_back(mk(1'b0, 2'b10, 32'h20, 32'h0));
    q1.push_back(mk(1'b0, 2'b10, 32'h20, 32'h0));
    run_until_idle(100);
    if (g + 1 < grant_log.size()) begin
      check_value("post_rst_first", 32'(grant_log[g]), 32'd0);
      check_value("post_rst_second", 32'(grant_log[g + 1]), 32'd1);
    end else check_value("post_rst_grants", 32'(grant_log.size() - g), 32'd2);
    if (r0 < rsp0_data.size()) check_value("kill_keep_p0", rsp0_data[r0], 32'hCAFEF00D);
    else check_value("kill_rsp_p0", 32'(rsp0_data.size() - r0), 32'd1);
    if (r1 < rsp1_data.size()) check_value("kill_keep_p1", rsp1_data[r1], 32'hCAFEF00D);
    else check_value("kill_rsp_p1", 32'(rsp1_data.size() - r1), 32'd1);

    // Lone port-1 request straight after reset.
    do_reset();
    g = grant_log.size();
    q1.push_back(mk(1'b0, 2'b10, 32'h60, 32'h0));
    run_until_idle(50);
    if (g < grant_log.size()) check_value("p1_alone", 32'(grant_log[g]), 32'd1);
    else check_value("p1_alone_cnt", 32'(grant_log.size() - g), 32'd1);

    // Random two-port traffic with withdrawals.
    rand_mode = 1'b1;
    repeat (900) tick();
    rand_mode = 1'b0;
    run_until_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
